transposed_coeff_ctrl: RTL and testbench
========================================

# transposed_coeff_ctrl

Coefficient-reload controller placed in front of `transposedFilterBlock`. It holds a host-writable shadow bank of filter coefficients and passes the sample stream to the filter. On a commit request it stalls the sample stream, shifts the shadow bank into the filter's coefficient chain, and optionally flushes the transposed delay line with zero samples before resuming. It is the only agent allowed to drive the filter's sample and coefficient inputs.

## Interface
Parameters:
- `CoeffCount`, 16: number of filter taps; must match the filter instance.
- `CoeffWidth`, 18: coefficient word width.
- `DataWidth`, 18: sample width.

Ports:
- `Clk_i`  in  1  single clock; all logic on the rising edge.
- `Rst_i`  in  1  reset; synchronous, active-high.
- `Data_i`  in  DataWidth  upstream sample.
- `DataNd_i`  in  1  upstream sample strobe.
- `Ready_o`  out  1  controller accepts samples; upstream must not strobe while low.
- `CoeffWe_i`  in  1  shadow-bank write strobe.
- `CoeffAddr_i`  in  clog2(CoeffCount)  shadow-bank address.
- `CoeffData_i`  in  CoeffWidth  shadow-bank write data.
- `Commit_i`  in  1  single-cycle pulse; load the shadow bank into the filter.
- `Data_o`  out  DataWidth  sample to the filter.
- `DataNd_o`  out  1  sample strobe to the filter.
- `CoeffData_o`  out  CoeffWidth  coefficient to the filter chain.
- `CoeffShift_o`  out  1  coefficient-chain shift enable.
- `CoeffDone_o`  out  1  one-cycle pulse when a reload completes.
- `Busy_o`  out  1  high in any state other than IDLE.
- `WrReject_o`  out  1  one-cycle pulse: a shadow write was dropped.
- `Overrun_o`  out  1  sticky flag: a sample was strobed while `Ready_o` was low.

## Operation
- States: IDLE, DRAIN, LOAD, FLUSH.
- Transitions: IDLE→DRAIN on commit; DRAIN→LOAD after 1 cycle; LOAD→FLUSH after `CoeffCount` cycles; FLUSH→IDLE after `CoeffCount` cycles.
- IDLE: `Data_o`/`DataNd_o` are registered copies of `Data_i`/`DataNd_i`.
- DRAIN: lets a sample accepted in the commit cycle reach the filter. `DataNd_o` = 0 afterwards.
- LOAD, step k = 0..CoeffCount-1:
  - `CoeffShift_o` = 1.
  - `CoeffData_o` = shadow[CoeffCount-1-k]. The highest index goes first; index 0 goes last.
- FLUSH: `DataNd_o` = 1 and `Data_o` = 0 for `CoeffCount` cycles.
- Shadow writes:
  - Accepted in IDLE, DRAIN and FLUSH.
  - A write in the commit cycle is included in that load.
  - Writes during LOAD are dropped; `WrReject_o` pulses 1 cycle later.
- Commit while `Busy_o`: latched as one pending request (further commits merge into it). The pending request is serviced in the first IDLE cycle as if `Commit_i` were asserted in that cycle.
- Samples strobed while `Ready_o` = 0 are discarded and set `Overrun_o`, which clears only on reset.
- Shadow bank contents are not reset. There is no automatic load after reset.

## Timing
- Reset values:
  - State IDLE; no pending request.
  - `Ready_o`=0 while `Rst_i` is high, 1 in the first cycle after reset.
  - All other outputs 0.
- Sample path latency in IDLE: 1 cycle.
- Commit sampled in cycle t (IDLE):
  - `Ready_o`=0 and DRAIN in t+1.
  - LOAD t+2..t+N+1.
  - FLUSH t+N+2..t+2N+1.
  - `CoeffDone_o` pulse and `Ready_o`=1 at t+2N+2.
- A sample with `DataNd_i` in cycle t is accepted and appears on `Data_o` at t+1.
- A pending commit serviced at IDLE cycle u leaves `Ready_o`=1 for cycle u only and low from u+1.

## Configuration
- `TRANSPOSED_FLUSH_EN` defined: FLUSH state is present, as described above.
- Not defined: LOAD→IDLE directly. `CoeffDone_o` and `Ready_o`=1 at t+N+2; the filter delay line keeps its old partial sums.

## Structure
- Package `transposed_pkg`:
  - state enum `coeff_ctrl_state_t`
  - default width constants
  - an address-width function equivalent to clog2 of `CoeffCount`.
- Sub-module `coeff_shadow_ram`: `CoeffCount`×`CoeffWidth` register array with one write port and one registered read port, indexed by the LOAD counter. The FSM, counter, pending flag and sample register stay in the top level.

## Test plan
- Write shadow[i]=i+1 for i=0..15, commit at t: `CoeffShift_o` high t+2..t+17 with data 16,15,…,1; 16 zero strobes t+18..t+33; `CoeffDone_o` at t+34.
- `DataNd_i`=1 with `Data_i`=0x1234 in the commit cycle: `Data_o`=0x1234 and `DataNd_o`=1 at t+1; `Overrun_o` stays 0.
- Strobe a sample at t+5 during reload: no `DataNd_o` from the input path, `Overrun_o`=1 until reset.
- Write at t+4 (LOAD): shadow unchanged, `WrReject_o` at t+5. Write at t+20 (FLUSH): accepted and visible in the next load.
- Two commits at t+3 and t+9: exactly one extra reload. `Ready_o` is high only at t+34, then the second reload starts.
- Assert `Rst_i` mid-LOAD: the next cycle is IDLE with all outputs 0, then `Ready_o`=1 the cycle after reset deasserts and the shadow contents are retained. Also run the `TRANSPOSED_FLUSH_EN`-undefined build: `CoeffDone_o` at t+18.

Source files
------------

// File: rtl/transposed_pkg.sv
// Shared definitions for the transposed-filter coefficient reload controller.
//   coeff_ctrl_state_t : controller state encoding (IDLE, DRAIN, LOAD, FLUSH)
//   Def*               : default widths and tap count
//   addrWidth()        : address bits needed to index a bank of 'count' entries
package transposed_pkg;

  localparam int DefCoeffCount = 16;
  localparam int DefCoeffWidth = 18;
  localparam int DefDataWidth  = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FLUSH = 2'd3
  } coeff_ctrl_state_t;

  // clog2 with a floor of one bit so a single-entry bank still has a port
  function automatic int addrWidth(input int count);
    int w;
    w = 1;
    while ((1 << w) < count) w++;
    return w;
  endfunction

endpackage

// File: rtl/coeff_shadow_ram.sv
// Shadow coefficient bank: CoeffCount x CoeffWidth registers.
//   Clk_i    : clock
//   We_i     : write strobe
//   WrAddr_i : write address
//   WrData_i : write data
//   RdAddr_i : read address (driven by the reload counter)
//   RdData_o : registered read data, valid one cycle after RdAddr_i
// A write to the address being read is forwarded so the new word is returned.
module coeff_shadow_ram
  import transposed_pkg::*;
#(
  parameter int CoeffCount = DefCoeffCount,
  parameter int CoeffWidth = DefCoeffWidth
) (
  input  logic                             Clk_i,
  input  logic                             We_i,
  input  logic [addrWidth(CoeffCount)-1:0] WrAddr_i,
  input  logic [CoeffWidth-1:0]            WrData_i,
  input  logic [addrWidth(CoeffCount)-1:0] RdAddr_i,
  output logic [CoeffWidth-1:0]            RdData_o
);

  logic signed [CoeffWidth-1:0] mem [CoeffCount];

  always_ff @(posedge Clk_i) begin
    if (We_i && (int'(WrAddr_i) < CoeffCount)) mem[WrAddr_i] <= WrData_i;
    if (We_i && (WrAddr_i == RdAddr_i)) RdData_o <= WrData_i;
    else                                RdData_o <= mem[RdAddr_i];
  end

endmodule

// File: rtl/transposed_coeff_ctrl.sv
// Coefficient reload controller in front of transposedFilterBlock.
// Passes samples through with one register of latency; on a commit it stalls
// the stream, shifts the shadow bank into the filter coefficient chain
// (highest index first) and, when TRANSPOSED_FLUSH_EN is defined, follows
// with CoeffCount zero samples to clear the transposed delay line.
// Ports:
//   Clk_i, Rst_i              : clock, synchronous active-high reset
//   Data_i, DataNd_i, Ready_o : upstream sample, strobe, accept
//   CoeffWe_i/Addr_i/Data_i   : shadow bank write port
//   Commit_i                  : request a reload (merged into one pending if busy)
//   Data_o, DataNd_o          : sample stream to the filter
//   CoeffData_o, CoeffShift_o : coefficient chain data and shift enable
//   CoeffDone_o               : one-cycle pulse at the end of a reload
//   Busy_o                    : not IDLE
//   WrReject_o                : one-cycle pulse, write dropped during LOAD
//   Overrun_o                 : sticky, sample strobed while not ready
// Build option: TRANSPOSED_FLUSH_EN enables the FLUSH phase.
module transposed_coeff_ctrl
  import transposed_pkg::*;
#(
  parameter int CoeffCount = DefCoeffCount,
  parameter int CoeffWidth = DefCoeffWidth,
  parameter int DataWidth  = DefDataWidth
) (
  input  logic                             Clk_i,
  input  logic                             Rst_i,
  input  logic [DataWidth-1:0]             Data_i,
  input  logic                             DataNd_i,
  output logic                             Ready_o,
  input  logic                             CoeffWe_i,
  input  logic [addrWidth(CoeffCount)-1:0] CoeffAddr_i,
  input  logic [CoeffWidth-1:0]            CoeffData_i,
  input  logic                             Commit_i,
  output logic [DataWidth-1:0]             Data_o,
  output logic                             DataNd_o,
  output logic [CoeffWidth-1:0]            CoeffData_o,
  output logic                             CoeffShift_o,
  output logic                             CoeffDone_o,
  output logic                             Busy_o,
  output logic                             WrReject_o,
  output logic                             Overrun_o
);

  localparam int AddrW = addrWidth(CoeffCount);
  localparam int CntW  = AddrW + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CoeffCount);

  localparam logic [1:0] StIdle  = ST_IDLE;
  localparam logic [1:0] StDrain = ST_DRAIN;
  localparam logic [1:0] StLoad  = ST_LOAD;
  localparam logic [1:0] StFlush = ST_FLUSH;

  logic [1:0]      state, nextState;
  logic [CntW-1:0] cnt;
  logic            pending;
  logic            commitReq;
  logic            phaseDone;
  logic            accept;
  logic            ramWe;
  logic [AddrW-1:0]      rdAddr;
  logic [CoeffWidth-1:0] ramRdData;

  logic readyReg, shiftReg, doneReg, wrRejReg, overrunReg;
  logic signed [DataWidth-1:0] sampleData_p1;
  logic                        sampleNd_p1;

  assign commitReq = Commit_i | pending;
  // cnt runs 1..CoeffCount inside LOAD and FLUSH
  assign phaseDone = (cnt == CntLast);
  assign accept    = (state == StIdle) && readyReg && DataNd_i;
  assign ramWe     = CoeffWe_i && (state != StLoad);

  always_comb begin
    nextState = state;
    case (state)
      StIdle:  if (commitReq) nextState = StDrain;
      StDrain: nextState = StLoad;
      StLoad: begin
        if (phaseDone) begin
`ifdef TRANSPOSED_FLUSH_EN
          nextState = StFlush;
`else
          nextState = StIdle;
`endif
        end
      end
      StFlush: if (phaseDone) nextState = StIdle;
      default: nextState = StIdle;
    endcase
  end

  // Read one step ahead: the RAM read port adds a cycle, so DRAIN fetches
  // the first (highest) word and LOAD step k fetches word for step k+1.
  always_comb begin
    rdAddr = '0;
    if (cnt < CntLast) rdAddr = AddrW'(CoeffCount - 1 - int'(cnt));
  end

  coeff_shadow_ram #(
    .CoeffCount (CoeffCount),
    .CoeffWidth (CoeffWidth)
  ) u_shadow (
    .Clk_i    (Clk_i),
    .We_i     (ramWe),
    .WrAddr_i (CoeffAddr_i),
    .WrData_i (CoeffData_i),
    .RdAddr_i (rdAddr),
    .RdData_o (ramRdData)
  );

  // Stage p0 -> p1: state, control outputs and the sample register
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state         <= StIdle;
      cnt           <= '0;
      pending       <= 1'b0;
      readyReg      <= 1'b0;
      shiftReg      <= 1'b0;
      doneReg       <= 1'b0;
      wrRejReg      <= 1'b0;
      overrunReg    <= 1'b0;
      sampleNd_p1   <= 1'b0;
      sampleData_p1 <= '0;
    end else begin
      state <= nextState;
      case (nextState)
        StLoad, StFlush: cnt <= (state == nextState) ? cnt + CntW'(1) : CntW'(1);
        default:         cnt <= '0;
      endcase
      // IDLE consumes the request; any commit seen while busy merges into one
      if (state == StIdle) pending <= 1'b0;
      else if (Commit_i)   pending <= 1'b1;
      readyReg      <= (nextState == StIdle);
      shiftReg      <= (nextState == StLoad);
      doneReg       <= (state != StIdle) && (nextState == StIdle);
      wrRejReg      <= CoeffWe_i && (state == StLoad);
      if (DataNd_i && !readyReg) overrunReg <= 1'b1;
      sampleNd_p1   <= accept || (nextState == StFlush);
      sampleData_p1 <= accept ? Data_i : '0;
    end
  end

  assign Ready_o      = readyReg;
  assign Data_o       = sampleData_p1;
  assign DataNd_o     = sampleNd_p1;
  assign CoeffShift_o = shiftReg;
  assign CoeffData_o  = shiftReg ? ramRdData : '0;
  assign CoeffDone_o  = doneReg;
  assign Busy_o       = (state != StIdle);
  assign WrReject_o   = wrRejReg;
  assign Overrun_o    = overrunReg;

endmodule

// File: tb/tb_transposed_coeff_ctrl.sv
module tb_transposed_coeff_ctrl;

  localparam int N  = 16;
  localparam int CW = 18;
  localparam int DW = 18;
  localparam int AW = 4;
`ifdef TRANSPOSED_FLUSH_EN
  localparam int F = N;
`else
  localparam int F = 0;
`endif
  localparam int DoneOff = N + 2 + F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] dataIn;
  logic          ndIn;
  logic          readyOut;
  logic          we;
  logic [AW-1:0] addr;
  logic [CW-1:0] wdata;
  logic          commit;
  logic [DW-1:0] dataOut;
  logic          ndOut;
  logic [CW-1:0] coeffOut;
  logic          shiftOut, doneOut, busyOut, rejOut, ovOut;

  transposed_coeff_ctrl #(.CoeffCount(N), .CoeffWidth(CW), .DataWidth(DW)) dut (
    .Clk_i(clk), .Rst_i(rst), .Data_i(dataIn), .DataNd_i(ndIn), .Ready_o(readyOut),
    .CoeffWe_i(we), .CoeffAddr_i(addr), .CoeffData_i(wdata), .Commit_i(commit),
    .Data_o(dataOut), .DataNd_o(ndOut), .CoeffData_o(coeffOut), .CoeffShift_o(shiftOut),
    .CoeffDone_o(doneOut), .Busy_o(busyOut), .WrReject_o(rejOut), .Overrun_o(ovOut)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: reload timeline anchored at the cycle a commit is serviced
  logic [CW-1:0] shadowM [N];
  int   tStart = -1;
  bit   pendM = 0, ovM = 0;
  logic expReady = 0, expNd = 0, expShift = 0, expDone = 0, expBusy = 0, expRej = 0;
  logic [DW-1:0] expData = '0;
  logic [CW-1:0] expCoeff = '0;

  // 0 idle, 1 drain, 2 load, 3 flush
  function automatic int phaseAt(input int m);
    int d;
    if (tStart < 0 || m <= tStart) return 0;
    d = m - tStart;
    if (d == 1) return 1;
    if (d <= N + 1) return 2;
    if (d <= N + 1 + F) return 3;
    return 0;
  endfunction

  task automatic modelStep();
    int ph, phN;
    bit readyNow, acc;
    if (rst) begin
      tStart = -1; pendM = 0; ovM = 0;
      expReady = 0; expNd = 0; expShift = 0; expDone = 0; expBusy = 0; expRej = 0;
      expData = '0; expCoeff = '0;
      return;
    end
    ph = phaseAt(cyc);
    readyNow = expReady;
    if (ph == 0 && (commit || pendM)) begin
      tStart = cyc; pendM = 0;
    end else if (ph != 0 && commit) begin
      pendM = 1;
    end
    if (we && ph != 2) shadowM[addr] = wdata;
    phN = phaseAt(cyc + 1);
    acc = (ph == 0) && readyNow && ndIn;
    expNd    = acc || (phN == 3);
    expData  = acc ? dataIn : '0;
    expShift = (phN == 2);
    expCoeff = (phN == 2) ? shadowM[N - 1 - (cyc + 1 - tStart - 2)] : '0;
    expDone  = (ph != 0) && (phN == 0);
    expRej   = we && (ph == 2);
    expBusy  = (phN != 0);
    expReady = (phN == 0);
    if (ndIn && !readyNow) ovM = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    chk("ready",    32'(readyOut), 32'(expReady));
    chk("dataNd",   32'(ndOut),    32'(expNd));
    chk("data",     32'(dataOut),  32'(expData));
    chk("shift",    32'(shiftOut), 32'(expShift));
    chk("coeff",    32'(coeffOut), 32'(expCoeff));
    chk("done",     32'(doneOut),  32'(expDone));
    chk("busy",     32'(busyOut),  32'(expBusy));
    chk("wrReject", 32'(rejOut),   32'(expRej));
    chk("overrun",  32'(ovOut),    32'(ovM));
  endtask

  task automatic idleInputs();
    ndIn = 0; dataIn = '0; we = 0; addr = '0; wdata = '0; commit = 0;
  endtask

  typedef struct {
    logic          nd;
    logic [DW-1:0] data;
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
    logic          expNd;
    logic [DW-1:0] expData;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t;
    int wrD;
    logic [31:0] expK;
    rst = 1;
    idleInputs();

    vecs[0] = '{1'b1, 18'h01234, 1'b0, 4'd0,  18'h00000, 1'b1, 18'h01234};
    vecs[1] = '{1'b0, 18'h3FFFF, 1'b0, 4'd0,  18'h00000, 1'b0, 18'h00000};
    vecs[2] = '{1'b1, 18'h3FFFF, 1'b1, 4'd2,  18'h00155, 1'b1, 18'h3FFFF};
    vecs[3] = '{1'b1, 18'h20000, 1'b0, 4'd0,  18'h00000, 1'b1, 18'h20000};
    vecs[4] = '{1'b1, 18'h00000, 1'b1, 4'd15, 18'h3FFFF, 1'b1, 18'h00000};
    vecs[5] = '{1'b0, 18'h00001, 1'b0, 4'd0,  18'h00000, 1'b0, 18'h00000};

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(readyOut), 0);
    chk("rst_busy",  32'(busyOut),  0);
    rst = 0;
    tick();
    chk("ready_after_rst", 32'(readyOut), 1);

    // Sample path in IDLE, one-cycle latency
    foreach (vecs[i]) begin
      ndIn = vecs[i].nd; dataIn = vecs[i].data;
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      tick();
      chk("vec_nd",   32'(ndOut),   32'(vecs[i].expNd));
      chk("vec_data", 32'(dataOut), 32'(vecs[i].expData));
      chk("vec_rej",  32'(rejOut),  0);
    end
    idleInputs();

    // Reload with shadow[i] = i+1 and a sample in the commit cycle
    for (int i = 0; i < N; i++) begin
      we = 1; addr = AW'(i); wdata = CW'(i + 1);
      tick();
    end
    idleInputs();
    commit = 1; ndIn = 1; dataIn = 18'h01234;
    t = cyc;
    tick();
    idleInputs();
    for (int d = 1; d <= DoneOff; d++) begin
      if (d == 1) begin
        chk("a_nd",       32'(ndOut),    1);
        chk("a_data",     32'(dataOut),  'h1234);
        chk("a_readyLow", 32'(readyOut), 0);
      end
      if (d >= 2 && d <= N + 1) begin
        chk("a_shift", 32'(shiftOut), 1);
        chk("a_coeff", 32'(coeffOut), 32'(N - (d - 2)));
      end
      if (d > N + 1 && d <= N + 1 + F) begin
        chk("a_flushNd",   32'(ndOut),   1);
        chk("a_flushData", 32'(dataOut), 0);
      end
      if (d == DoneOff - 1) chk("a_doneEarly", 32'(doneOut), 0);
      if (d == DoneOff) begin
        chk("a_done",    32'(doneOut),  1);
        chk("a_ready",   32'(readyOut), 1);
        chk("a_overrun", 32'(ovOut),    0);
      end
      tick();
    end

    // Reload with rejected write, overrun, accepted write and a merged pending commit
    wrD = (F > 0) ? 20 : DoneOff;
    commit = 1;
    t = cyc;
    tick();
    for (int d = 1; d <= 2 * DoneOff; d++) begin
      idleInputs();
      if (d == 5) chk("b_wrReject", 32'(rejOut), 1);
      if (d == 6) begin
        chk("b_ndDropped", 32'(ndOut), 0);
        chk("b_overrun",   32'(ovOut), 1);
      end
      if (d >= 2 && d <= N + 1) chk("b_coeff1", 32'(coeffOut), 32'(N - (d - 2)));
      if (d < DoneOff) chk("b_readyLow", 32'(readyOut), 0);
      if (d == DoneOff) begin
        chk("b_readyPend", 32'(readyOut), 1);
        chk("b_done1",     32'(doneOut),  1);
      end
      if (d == DoneOff + 1) begin
        chk("b_readyDrop", 32'(readyOut), 0);
        chk("b_busy2",     32'(busyOut),  1);
      end
      if (d >= DoneOff + 2 && d <= DoneOff + N + 1) begin
        expK = (d - DoneOff - 2 == 10) ? 32'h2BBBB : 32'(N - (d - DoneOff - 2));
        chk("b_coeff2", 32'(coeffOut), expK);
      end
      if (d == 2 * DoneOff) begin
        chk("b_done2",    32'(doneOut), 1);
        chk("b_ovSticky", 32'(ovOut),   1);
      end
      if (d == 3 || d == 9) commit = 1;
      if (d == 4) begin we = 1; addr = 4'd3; wdata = 18'h3AAAA; end
      if (d == 5) begin ndIn = 1; dataIn = 18'h05555; end
      if (d == wrD) begin we = 1; addr = 4'd5; wdata = 18'h2BBBB; end
      tick();
    end
    idleInputs();

    // Reset in the middle of LOAD
    commit = 1;
    tick();
    idleInputs();
    for (int d = 1; d < 6; d++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("c_busy",    32'(busyOut),  0);
    chk("c_ready",   32'(readyOut), 0);
    chk("c_shift",   32'(shiftOut), 0);
    chk("c_coeff",   32'(coeffOut), 0);
    chk("c_nd",      32'(ndOut),    0);
    chk("c_data",    32'(dataOut),  0);
    chk("c_done",    32'(doneOut),  0);
    chk("c_rej",     32'(rejOut),   0);
    chk("c_overrun", 32'(ovOut),    0);
    tick();
    chk("c_readyBack", 32'(readyOut), 1);
    commit = 1;
    tick();
    commit = 0;
    for (int d = 1; d <= DoneOff; d++) begin
      if (d >= 2 && d <= N + 1) begin
        expK = (d - 2 == 10) ? 32'h2BBBB : 32'(N - (d - 2));
        chk("c_retained", 32'(coeffOut), expK);
      end
      if (d == DoneOff) chk("c_done2", 32'(doneOut), 1);
      tick();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      commit = !rst && ($urandom_range(0, 39) == 0);
      we     = !rst && ($urandom_range(0, 3) == 0);
      addr   = AW'($urandom_range(0, N - 1));
      wdata  = CW'($urandom);
      ndIn   = expReady ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
      dataIn = DW'($urandom);
      tick();
    end
    rst = 0;
    idleInputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
